// File: rtl/if_pipe_stage.sv
// -----------------------------------------------------------------------------
// if_pipe_stage: instruction-fetch stage of a 5-stage in-order pipeline.
// Holds the PC, drives the instruction memory address, and registers the
// fetched word plus its pc+4 into the IF/ID pipeline register.
//
// Next-PC priority: branch_taken > jump > sequential (pc_write_en) > hold.
// A redirect always loads the PC and flushes IF/ID to a bubble, even while
// the hazard unit is stalling.
//
// Optional feature: define IF_PERF_CNT_EN to build the stall/redirect
// performance counters; otherwise stall_cnt/redirect_cnt read as zero.
// -----------------------------------------------------------------------------
module if_pipe_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,           // synchronous, active low
    input  logic        pc_write_en,
    input  logic        if_id_write_en,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic [31:0] stall_cnt,
    output logic [31:0] redirect_cnt
);

    logic [31:0] r_pc;
    logic [31:0] r_if_id_instr;
    logic [31:0] r_if_id_pc_plus4;
    logic        r_if_id_valid;

    logic        w_redirect;
    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_next;

    assign w_redirect = branch_taken | jump;
    assign w_pc_plus4 = r_pc + 32'd4;     // wraps modulo 2^32 by width

    // Select the redirect target (branch beats jump) and force word alignment.
    always_comb begin
        w_target = jump_target;
        if (branch_taken) begin
            w_target = branch_target;
        end
        w_target[1:0] = 2'b00;
    end

    // Next-PC mux: redirect overrides the stall, otherwise advance or hold.
    always_comb begin
        w_pc_next = r_pc;
        if (w_redirect) begin
            w_pc_next = w_target;
        end else if (pc_write_en) begin
            w_pc_next = w_pc_plus4;
        end
    end

    // PC register; reset dominates everything.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    // IF/ID register: flush on redirect beats the stall, else load or hold.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_if_id_instr    <= NOP_INSTR;
            r_if_id_pc_plus4 <= 32'h0000_0000;
            r_if_id_valid    <= 1'b0;
        end else if (w_redirect) begin
            r_if_id_instr    <= NOP_INSTR;
            r_if_id_pc_plus4 <= w_pc_plus4;
            r_if_id_valid    <= 1'b0;
        end else if (if_id_write_en) begin
            r_if_id_instr    <= imem_rdata;
            r_if_id_pc_plus4 <= w_pc_plus4;
            r_if_id_valid    <= 1'b1;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_redirect_cnt;

    // Performance counters: stalled cycles without redirect, and redirects.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stall_cnt    <= 32'h0000_0000;
            r_redirect_cnt <= 32'h0000_0000;
        end else begin
            if (w_redirect) begin
                r_redirect_cnt <= r_redirect_cnt + 32'd1;
            end else if (!pc_write_en) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt    = r_stall_cnt;
    assign redirect_cnt = r_redirect_cnt;
`else
    assign stall_cnt    = 32'h0000_0000;
    assign redirect_cnt = 32'h0000_0000;
`endif

    assign pc             = r_pc;
    assign imem_addr      = r_pc;
    assign pc_plus4       = w_pc_plus4;
    assign if_id_instr    = r_if_id_instr;
    assign if_id_pc_plus4 = r_if_id_pc_plus4;
    assign if_id_valid    = r_if_id_valid;

endmodule

// File: tb/tb_if_pipe_stage.sv
// -----------------------------------------------------------------------------
// Testbench for if_pipe_stage. A reference model computes the expected state
// after every edge; the expectation is queued when stimulus is driven and
// popped/compared one edge later. Honors IF_PERF_CNT_EN for counter checks.
// -----------------------------------------------------------------------------
module tb_if_pipe_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        pc_write_en;
    logic        if_id_write_en;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic [31:0] stall_cnt;
    logic [31:0] redirect_cnt;

    if_pipe_stage #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .pc_write_en    (pc_write_en),
        .if_id_write_en (if_id_write_en),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .jump           (jump),
        .jump_target    (jump_target),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid),
        .stall_cnt      (stall_cnt),
        .redirect_cnt   (redirect_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: a fixed word at 0, address-derived elsewhere.
    function automatic logic [31:0] imem_fn(input logic [31:0] a);
        if (a == 32'h0000_0000) return 32'h2008_0005;
        return a ^ 32'h5A5A_0033;
    endfunction

    assign imem_rdata = imem_fn(imem_addr);

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pp4;
        logic        valid;
        logic [31:0] sc;
        logic [31:0] rc;
    } exp_t;

    exp_t sb[$];

    int cmp_cnt = 0;
    int err_cnt = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pp4;
    logic        m_valid;
    logic [31:0] m_sc;
    logic [31:0] m_rc;
    bit          m_known = 0;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst_n, input logic pwe, input logic iwe,
                        input logic bt, input logic [31:0] bta,
                        input logic j, input logic [31:0] jta);
        exp_t        e;
        exp_t        got;
        logic        redir;
        logic [31:0] tgt;
        logic [31:0] pp4;
        @(negedge clk);
        reset          = rst_n;
        pc_write_en    = pwe;
        if_id_write_en = iwe;
        branch_taken   = bt;
        branch_target  = bta;
        jump           = j;
        jump_target    = jta;
        #1;
        if (m_known) begin
            chk32("imem_addr", imem_addr, m_pc);
            chk32("pc_plus4", pc_plus4, m_pc + 32'd4);
        end
        // model the coming edge
        pp4   = m_pc + 32'd4;
        redir = bt | j;
        tgt   = (bt ? bta : jta) & 32'hFFFF_FFFC;
        if (!rst_n) begin
            m_pc = RESET_PC; m_instr = NOP_INSTR; m_pp4 = 32'h0; m_valid = 1'b0;
            m_sc = 32'h0; m_rc = 32'h0; m_known = 1;
        end else begin
            if (redir) begin
                m_instr = NOP_INSTR; m_pp4 = pp4; m_valid = 1'b0;
                m_rc    = m_rc + 32'd1;
            end else begin
                if (iwe) begin
                    m_instr = imem_fn(m_pc); m_pp4 = pp4; m_valid = 1'b1;
                end
                if (!pwe) m_sc = m_sc + 32'd1;
            end
            if (redir)     m_pc = tgt;
            else if (pwe)  m_pc = pp4;
        end
        e.pc = m_pc; e.instr = m_instr; e.pp4 = m_pp4; e.valid = m_valid;
`ifdef IF_PERF_CNT_EN
        e.sc = m_sc; e.rc = m_rc;
`else
        e.sc = 32'h0; e.rc = 32'h0;
`endif
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk32("pc", pc, got.pc);
        chk32("if_id_instr", if_id_instr, got.instr);
        chk32("if_id_pc_plus4", if_id_pc_plus4, got.pp4);
        chk32("if_id_valid", {31'b0, if_id_valid}, {31'b0, got.valid});
        chk32("stall_cnt", stall_cnt, got.sc);
        chk32("redirect_cnt", redirect_cnt, got.rc);
        $display("step rst=%0b pwe=%0b iwe=%0b bt=%0b j=%0b -> pc=%h instr=%h pp4=%h v=%0b sc=%0d rc=%0d",
                 rst_n, pwe, iwe, bt, j, pc, if_id_instr, if_id_pc_plus4, if_id_valid,
                 stall_cnt, redirect_cnt);
    endtask

    // Shorthand for a plain sequential fetch
    task automatic seq();
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        reset = 1'b0; pc_write_en = 1'b1; if_id_write_en = 1'b1;
        branch_taken = 1'b0; branch_target = 32'h0; jump = 1'b0; jump_target = 32'h0;

        // Reset held 3 cycles while a branch is requested: reset dominates
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
        chk32("rst_pc", pc, RESET_PC);
        chk32("rst_valid", {31'b0, if_id_valid}, 32'h0);

        // Release: first fetch from RESET_PC, word 2008_0005
        seq();
        chk32("edge1_instr", if_id_instr, 32'h2008_0005);
        chk32("edge1_pp4", if_id_pc_plus4, 32'h4);
        chk32("edge1_pc", pc, 32'h4);
        seq();
        chk32("edge2_pc", pc, 32'h8);
        seq(); seq();
        chk32("pc_0x10", pc, 32'h10);

        // One-cycle full stall at 0x10
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk32("stall_pc", pc, 32'h10);
        seq();
        chk32("after_stall_pc", pc, 32'h14);
        seq(); seq(); seq();
        chk32("pc_0x20", pc, 32'h20);

        // Stall plus taken branch to misaligned 0x83: redirect wins, flush
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h83, 1'b0, 32'h0);
        chk32("br_pc", pc, 32'h80);
        chk32("br_instr", if_id_instr, NOP_INSTR);
        seq();

        // Branch and jump together: branch wins
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h100, 1'b1, 32'h200);
        chk32("br_jmp_pc", pc, 32'h100);

        // Jump to top of memory and wrap
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFE);
        chk32("top_pc", pc, 32'hFFFF_FFFC);
        seq();
        chk32("wrap_pc", pc, 32'h0);

        // IF/ID stall only, then PC stall only
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);

        // Random mix of stalls and redirects
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 5) == 0), $urandom,
                 1'($urandom_range(0, 5) == 0), $urandom);
        end

        // Mid-run reset with stall and redirect asserted
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h44, 1'b1, 32'h88);
        seq(); seq();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/if_pipe_stage.md
IF_PIPE_STAGE -- requirements
Module: if_pipe_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0000: instruction injected into IF/ID on flush or reset.
REQ-003 SHALL have one clock and a synchronous, active-low reset; ports are clk and reset; reset is sampled only on the rising edge of clk.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous active-low reset; 0 = reset.
REQ-006 pc_write_en  input  1  1 = PC may update; 0 = hold PC (load-use stall from hazard unit).
REQ-007 if_id_write_en  input  1  1 = IF/ID may load; 0 = hold IF/ID.
REQ-008 branch_taken  input  1  taken branch resolved downstream.
REQ-009 branch_target  input  32  branch destination address.
REQ-010 jump  input  1  jump decoded in ID.
REQ-011 jump_target  input  32  jump destination address.
REQ-012 imem_addr  output  32  instruction memory byte address (combinational copy of PC).
REQ-013 imem_rdata  input  32  instruction word; combinational read of imem_addr.
REQ-014 pc  output  32  current PC register.
REQ-015 pc_plus4  output  32  pc + 4, combinational.
REQ-016 if_id_instr  output  32  registered instruction handed to ID.
REQ-017 if_id_pc_plus4  output  32  registered pc_plus4 handed to ID.
REQ-018 if_id_valid  output  1  1 = if_id_instr is a real fetched instruction; 0 = bubble.
REQ-019 stall_cnt  output  32  cycles with pc_write_en=0 (see Configuration).
REQ-020 redirect_cnt  output  32  count of accepted redirects (see Configuration).

Function
REQ-021 Next-PC priority SHALL be: branch_taken -> branch_target; else jump -> jump_target; else pc_write_en=1 -> pc_plus4; else hold.
REQ-022 A redirect (branch_taken or jump) SHALL load PC even when pc_write_en=0; redirect overrides stall.
REQ-023 Bits [1:0] of any loaded target SHALL be forced to 2'b00; pc is always word aligned.
REQ-024 PC arithmetic SHALL be 32-bit modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 without a flag.
REQ-025 On a redirect, IF/ID SHALL load NOP_INSTR with if_id_valid=0 on the same edge, regardless of if_id_write_en (flush beats stall).
REQ-026 With no redirect and if_id_write_en=1, IF/ID SHALL load {imem_rdata, pc_plus4} with if_id_valid=1.
REQ-027 With no redirect and if_id_write_en=0, IF/ID SHALL hold all three fields.
REQ-028 Fetch latency SHALL be one cycle: the instruction at PC appears on if_id_instr after the next rising edge.
REQ-029 A one-cycle stall (pc_write_en=if_id_write_en=0) SHALL make pc repeat exactly one value and IF/ID repeat exactly one instruction.
REQ-030 branch_taken and jump asserted together SHALL take branch_target only; redirect_cnt increments by 1.

Reset
REQ-031 While reset=0 at a rising edge: pc=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc_plus4=0, if_id_valid=0, stall_cnt=0, redirect_cnt=0.
REQ-032 Reset SHALL dominate stall, redirect and all other inputs on the same edge.
REQ-033 First edge with reset=1 SHALL fetch from RESET_PC; if_id_valid rises on that edge.

Configuration
REQ-034 Macro IF_PERF_CNT_EN defined: stall_cnt increments (wrapping) on each edge with reset=1 and pc_write_en=0 and no redirect; redirect_cnt increments (wrapping) on each edge with a redirect.
REQ-035 IF_PERF_CNT_EN undefined: counter registers SHALL not be built; stall_cnt and redirect_cnt are tied to 32'h0; all other behaviour identical.

Verification
REQ-036 Reset held 3 cycles with branch_taken=1, target 32'h40 -> pc=RESET_PC, if_id_valid=0; release -> pc sequence RESET_PC, +4, +8.
REQ-037 Sequential run from 0, imem_rdata=32'h2008_0005 at 0 -> after edge 1 if_id_instr=32'h2008_0005, if_id_pc_plus4=32'h4, pc=32'h4.
REQ-038 pc=32'h10, pc_write_en=if_id_write_en=0 for one cycle -> pc stays 32'h10 one extra cycle, IF/ID unchanged, stall_cnt=1 (macro on).
REQ-039 pc=32'h20, stall active and branch_taken=1, branch_target=32'h83 -> next pc=32'h80, if_id_instr=NOP_INSTR, if_id_valid=0, redirect_cnt=1.
REQ-040 branch_taken=1 (32'h100) and jump=1 (32'h200) same cycle -> pc=32'h100; pc=32'hFFFF_FFFC sequential -> pc=32'h0.
REQ-041 Macro off build, 20 cycles with stalls and redirects -> stall_cnt=redirect_cnt=32'h0, PC/IF/ID trace identical to macro-on build.
